dmem_bridge: RTL and testbench
==============================

Name: dmem_bridge

Overview:
- Data-memory bridge on the MEM-stage port of the 5-stage MIPS pipeline; converts the datapath's single-cycle mem_ren/mem_wen/mem_addr/mem_dout/mem_din interface into a variable-latency req/ack bus.
- Asserts stall to freeze the pipeline while an access is outstanding.
- Flags bus timeouts and misaligned word accesses.

Parameters:
- ADDR_W, 32, bus address width; low ADDR_W bits of mem_addr are driven.
- TIMEOUT, 255, max BUSY cycles waiting for bus_ack before abort; range 1..65535.
- ERR_DATA, 32'hDEAD_BEEF, load data returned on timeout.

Ports:
- clk  in  1  main clock, rising edge
- cpu_rst_n  in  1  reset, asynchronous, active-low
- cpu_en  in  1  debug-control CPU enable; no new access accepted while low
- mem_ren  in  1  load request from EX/MEM
- mem_wen  in  1  store request from EX/MEM
- mem_addr  in  32  byte address from EX/MEM ALU result
- mem_dout  in  32  store data from pipeline
- mem_din  out  32  load data to pipeline
- stall  out  1  pipeline freeze; pipeline registers hold while high
- bus_req  out  1  bus request, registered
- bus_we  out  1  1=write, 0=read; registered
- bus_addr  out  ADDR_W  word-aligned bus address; registered
- bus_wdata  out  32  write data; registered
- bus_ack  in  1  one-cycle completion strobe
- bus_rdata  in  32  read data, valid with bus_ack
- bus_err  out  1  sticky error (timeout or misalign); cleared only by reset

Behaviour:
- Reset (async, cpu_rst_n=0): state=IDLE; bus_req=0, bus_we=0, bus_addr=0, bus_wdata=0, mem_din=0, bus_err=0, timeout counter=0. stall=0 while in reset. Reset mid-BUSY drops bus_req immediately; the transaction is abandoned.
- access = cpu_en & (mem_ren | mem_wen). When both enables are high, the write wins.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - stall = access (combinational).
  - access with mem_addr[1:0]==0: latch we/addr/wdata; BUSY next cycle with bus_req=1.
  - access with mem_addr[1:0]!=0: no bus cycle; set bus_err; mem_din<=0; go to DONE.
- BUSY:
  - stall=1; bus_req held high; counter increments each cycle.
  - bus_ack: mem_din<=bus_rdata (read) or unchanged (write); bus_req<=0; go to DONE.
  - counter reaches TIMEOUT without ack: bus_req<=0; bus_err<=1; mem_din<=ERR_DATA on a read; go to DONE.
  - An ack in the same cycle the counter hits TIMEOUT counts as success.
  - cpu_en low in BUSY does not abort; the transaction completes.
- DONE:
  - stall=0 for exactly one cycle so the pipeline advances and MEM/WB captures mem_din.
  - Inputs are ignored; the same access is still presented and must not re-issue. Go to IDLE.
- Minimum latency: access cycle, then BUSY with ack in its first cycle, then DONE. That is 2 stall cycles per access; N-cycle ack latency gives N+1 stall cycles.
- Back-to-back memory instructions: the second is seen in IDLE the cycle after DONE; there is no dead cycle beyond that.
- mem_din holds its last value outside DONE.
- A stray bus_ack in IDLE or DONE is ignored.

Optional Feature:
- Macro: DMEM_WBUF_EN.
- Defined: single-entry posted write buffer.
  - A store in IDLE with the buffer empty: stall=0 that cycle (pipeline advances); data/address are latched into the buffer; bus_req=1 next cycle; the write drains in BUSY-style with the same timeout.
  - Any access (load or store) arriving while the buffer is draining: stall=1 until drain completes, then normal handling.
  - Posted-write timeout or misalign sets bus_err only.
- Undefined: every store stalls as specified above.

Test Plan:
- Aligned load addr 0x0000_0010, bus_ack 3 cycles after bus_req rises, bus_rdata=0x1234_5678 -> stall high 4 cycles, bus_addr=0x10, bus_we=0; DONE cycle has stall=0 and mem_din=0x1234_5678; exactly one bus_req pulse train.
- Store addr 0x20 data 0xCAFE_F00D, ack in 1st BUSY cycle -> bus_we=1, bus_wdata=0xCAFE_F00D, stall high 2 cycles. With DMEM_WBUF_EN: stall=0 on issue, bus_req next cycle.
- Two consecutive loads 0x4 and 0x8, ack latency 1 -> two distinct bus transactions in order; no re-issue of 0x4 in its DONE cycle.
- Load with no ack, TIMEOUT=4 -> bus_req drops after 4 BUSY cycles; bus_err=1 sticky; mem_din=0xDEAD_BEEF in DONE.
- Load addr 0x0000_0003 -> no bus_req; bus_err=1; one stall cycle; mem_din=0.
- cpu_rst_n low for 1 cycle mid-BUSY -> bus_req, stall, bus_err drop asynchronously; after release, state IDLE and the next access proceeds normally.

Source files
------------

// File: rtl/dmem_bridge.sv
// rtl/dmem_bridge.sv - MEM-stage data-memory bridge to a variable-latency req/ack bus
// Optional posted write buffer: define DMEM_WBUF_EN (default build: every store stalls).
module dmem_bridge #(
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned TIMEOUT  = 255,
  parameter logic [31:0] ERR_DATA = 32'hDEAD_BEEF
) (
  input  logic              clk,
  input  logic              cpu_rst_n,
  input  logic              cpu_en,
  input  logic              mem_ren,
  input  logic              mem_wen,
  input  logic [31:0]       mem_addr,
  input  logic [31:0]       mem_dout,
  output logic [31:0]       mem_din,
  output logic              stall,
  output logic              bus_req,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [31:0]       bus_wdata,
  input  logic              bus_ack,
  input  logic [31:0]       bus_rdata,
  output logic              bus_err
);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  localparam logic [15:0] TMO = TIMEOUT[15:0];

  state_t              state_q, state_d;
  logic                bus_req_q, bus_req_d;
  logic                bus_we_q, bus_we_d;
  logic [ADDR_W-1:0]   bus_addr_q, bus_addr_d;
  logic [31:0]         bus_wdata_q, bus_wdata_d;
  logic [31:0]         mem_din_q, mem_din_d;
  logic                bus_err_q, bus_err_d;
  logic [15:0]         cnt_q, cnt_d;

  logic                access;
  logic                aligned;
  logic [15:0]         cnt_inc;
  logic                timeout_hit;
  logic                post_store;   // store accepted into the posted buffer this cycle
  logic                posted;       // current BUSY transaction is a posted write

  assign access      = cpu_en & (mem_ren | mem_wen);
  assign aligned     = (mem_addr[1:0] == 2'b00);
  assign cnt_inc     = cnt_q + 16'd1;
  assign timeout_hit = (cnt_inc == TMO);

`ifdef DMEM_WBUF_EN
  logic posted_q, posted_d;
  assign post_store = access & mem_wen;
  assign posted     = posted_q;
`else
  assign post_store = 1'b0;
  assign posted     = 1'b0;
`endif

  // State register plus all registered bus/pipeline outputs
  always_ff @(posedge clk or negedge cpu_rst_n) begin
    if (!cpu_rst_n) begin
      state_q     <= S_IDLE;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
      mem_din_q   <= '0;
      bus_err_q   <= 1'b0;
      cnt_q       <= '0;
`ifdef DMEM_WBUF_EN
      posted_q    <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      bus_req_q   <= bus_req_d;
      bus_we_q    <= bus_we_d;
      bus_addr_q  <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
      mem_din_q   <= mem_din_d;
      bus_err_q   <= bus_err_d;
      cnt_q       <= cnt_d;
`ifdef DMEM_WBUF_EN
      posted_q    <= posted_d;
`endif
    end
  end

  // Next-state: accept in IDLE, wait for ack/timeout in BUSY, one release cycle in DONE
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (access) begin
          if (!aligned) state_d = post_store ? S_IDLE : S_DONE;
          else          state_d = S_BUSY;
        end
      end
      S_BUSY: begin
        if (bus_ack || timeout_hit) state_d = posted ? S_IDLE : S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath: latch the access, count BUSY cycles, capture read data or error data
  always_comb begin
    bus_req_d   = bus_req_q;
    bus_we_d    = bus_we_q;
    bus_addr_d  = bus_addr_q;
    bus_wdata_d = bus_wdata_q;
    mem_din_d   = mem_din_q;
    bus_err_d   = bus_err_q;
    cnt_d       = cnt_q;
`ifdef DMEM_WBUF_EN
    posted_d    = posted_q;
`endif
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (access) begin
          if (aligned) begin
            bus_req_d   = 1'b1;
            bus_we_d    = mem_wen;
            bus_addr_d  = {mem_addr[ADDR_W-1:2], 2'b00};
            bus_wdata_d = mem_dout;
`ifdef DMEM_WBUF_EN
            posted_d    = post_store;
`endif
          end else begin
            bus_err_d = 1'b1;
            if (!post_store) mem_din_d = '0;
          end
        end
      end
      S_BUSY: begin
        cnt_d = cnt_inc;
        // An ack coinciding with the last allowed cycle is a success
        if (bus_ack) begin
          bus_req_d = 1'b0;
          if (!bus_we_q) mem_din_d = bus_rdata;
        end else if (timeout_hit) begin
          bus_req_d = 1'b0;
          bus_err_d = 1'b1;
          if (!bus_we_q) mem_din_d = ERR_DATA;
        end
      end
      default: begin
`ifdef DMEM_WBUF_EN
        posted_d = 1'b0;
`endif
      end
    endcase
  end

  // Outputs: stall while an access waits; DONE releases the pipeline for one cycle
  always_comb begin
    stall = 1'b0;
    case (state_q)
      S_IDLE:  stall = access & ~post_store;
      S_BUSY:  stall = posted ? access : 1'b1;
      default: stall = 1'b0;
    endcase
    stall = stall & cpu_rst_n;
  end

  assign mem_din   = mem_din_q;
  assign bus_req   = bus_req_q;
  assign bus_we    = bus_we_q;
  assign bus_addr  = bus_addr_q;
  assign bus_wdata = bus_wdata_q;
  assign bus_err   = bus_err_q;

endmodule

// File: tb/tb_dmem_bridge.sv
// tb/tb_dmem_bridge.sv - scoreboard bench for dmem_bridge (default build, TIMEOUT=4)
module tb_dmem_bridge;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } txn_t;

  logic        clk = 1'b0;
  logic        cpu_rst_n;
  logic        cpu_en;
  logic        mem_ren;
  logic        mem_wen;
  logic [31:0] mem_addr;
  logic [31:0] mem_dout;
  logic [31:0] mem_din;
  logic        stall;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic        bus_ack;
  logic [31:0] bus_rdata;
  logic        bus_err;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          req_rises = 0;
  int          ack_lat = 0;
  logic [31:0] rdata_val = '0;
  txn_t        exp_q[$];

  dmem_bridge #(.ADDR_W(32), .TIMEOUT(4), .ERR_DATA(32'hDEAD_BEEF)) dut (
    .clk(clk), .cpu_rst_n(cpu_rst_n), .cpu_en(cpu_en),
    .mem_ren(mem_ren), .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_dout(mem_dout),
    .mem_din(mem_din), .stall(stall),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_ack(bus_ack), .bus_rdata(bus_rdata), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Bus responder: ack in the ack_lat-th cycle of bus_req (0 = never)
  initial begin
    int rc;
    rc = 0;
    bus_ack = 1'b0;
    bus_rdata = '0;
    forever begin
      @(negedge clk);
      bus_rdata = rdata_val;
      if (bus_req === 1'b1) begin
        rc++;
        bus_ack = (ack_lat != 0) && (rc == ack_lat);
      end else begin
        rc = 0;
        bus_ack = 1'b0;
      end
    end
  end

  // Bus monitor: every new request must match the oldest expected transaction
  initial begin
    logic req_prev;
    txn_t t;
    req_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (bus_req === 1'b1 && !req_prev) begin
        req_rises++;
        if (exp_q.size() == 0) begin
          check("unexpected_req", {31'd0, bus_req}, 32'd0);
        end else begin
          t = exp_q.pop_front();
          check("bus_we", {31'd0, bus_we}, {31'd0, t.we});
          check("bus_addr", bus_addr, t.addr);
          if (t.we) check("bus_wdata", bus_wdata, t.wdata);
        end
      end
      req_prev = bus_req;
    end
  end

  // One pipeline access: present it, count stall cycles, check the DONE-cycle result
  task automatic do_access(input logic ren, input logic wen, input logic [31:0] addr,
                           input logic [31:0] wdata, input int lat, input logic [31:0] rdata,
                           input logic [31:0] exp_din, input int exp_stall, input logic exp_err);
    int n;
    int r0;
    txn_t t;
    @(negedge clk);
    cpu_en = 1'b1; mem_ren = ren; mem_wen = wen; mem_addr = addr; mem_dout = wdata;
    ack_lat = lat; rdata_val = rdata;
    if (addr[1:0] == 2'b00) begin
      t.we = wen; t.addr = addr; t.wdata = wdata;
      exp_q.push_back(t);
    end
    r0 = req_rises;
    #1;
    n = 0;
    while (stall === 1'b1 && n < 50) begin
      n++;
      @(negedge clk);
      #1;
    end
    check("stall_cycles", n, exp_stall);
    check("mem_din", mem_din, exp_din);
    check("bus_err", {31'd0, bus_err}, {31'd0, exp_err});
    check("req_trains", req_rises - r0, (addr[1:0] == 2'b00) ? 32'd1 : 32'd0);
  endtask

  initial begin
    int r0;
    cpu_rst_n = 1'b0; cpu_en = 1'b1; mem_ren = 1'b1; mem_wen = 1'b0;
    mem_addr = 32'h10; mem_dout = '0;
    repeat (2) @(negedge clk);
    check("rst_stall", {31'd0, stall}, 32'd0);
    check("rst_bus_req", {31'd0, bus_req}, 32'd0);
    check("rst_bus_we", {31'd0, bus_we}, 32'd0);
    check("rst_bus_addr", bus_addr, 32'd0);
    check("rst_bus_wdata", bus_wdata, 32'd0);
    check("rst_mem_din", mem_din, 32'd0);
    check("rst_bus_err", {31'd0, bus_err}, 32'd0);
    mem_ren = 1'b0;
    @(negedge clk);
    cpu_rst_n = 1'b1;

    // Aligned load, ack in 3rd BUSY cycle
    do_access(1, 0, 32'h10, 32'h0, 3, 32'h1234_5678, 32'h1234_5678, 4, 0);
    // Store, ack in 1st BUSY cycle; mem_din untouched
    do_access(0, 1, 32'h20, 32'hCAFE_F00D, 1, 32'h0BAD_0BAD, 32'h1234_5678, 2, 0);
    // Back-to-back loads, no re-issue during DONE
    do_access(1, 0, 32'h4, 32'h0, 1, 32'hAAAA_0004, 32'hAAAA_0004, 2, 0);
    do_access(1, 0, 32'h8, 32'h0, 1, 32'hBBBB_0008, 32'hBBBB_0008, 2, 0);
    // Both enables high: write wins
    do_access(1, 1, 32'h30, 32'h55AA_55AA, 2, 32'h0BAD_0BAD, 32'hBBBB_0008, 3, 0);

    // cpu_en low: nothing accepted
    @(negedge clk);
    cpu_en = 1'b0; mem_ren = 1'b1; mem_wen = 1'b0; mem_addr = 32'h70;
    r0 = req_rises;
    #1;
    check("dis_stall", {31'd0, stall}, 32'd0);
    repeat (3) @(negedge clk);
    check("dis_no_req", req_rises - r0, 32'd0);
    cpu_en = 1'b1; mem_ren = 1'b0;

    // Ack in the same cycle the counter reaches TIMEOUT: success
    do_access(1, 0, 32'h50, 32'h0, 4, 32'h5050_5050, 32'h5050_5050, 5, 0);
    // No ack: timeout after 4 BUSY cycles
    do_access(1, 0, 32'h60, 32'h0, 0, 32'h0, 32'hDEAD_BEEF, 5, 1);
    @(negedge clk);
    mem_ren = 1'b0;
    repeat (2) @(negedge clk);
    check("err_sticky", {31'd0, bus_err}, 32'd1);

    // Reset mid-BUSY drops everything asynchronously
    begin
      txn_t t;
      t.we = 1'b0; t.addr = 32'h40; t.wdata = '0;
      exp_q.push_back(t);
      mem_ren = 1'b1; mem_addr = 32'h40; ack_lat = 0;
      repeat (2) @(negedge clk);
      check("mid_busy_req", {31'd0, bus_req}, 32'd1);
      cpu_rst_n = 1'b0;
      #1;
      check("arst_bus_req", {31'd0, bus_req}, 32'd0);
      check("arst_stall", {31'd0, stall}, 32'd0);
      check("arst_bus_err", {31'd0, bus_err}, 32'd0);
      mem_ren = 1'b0;
      @(negedge clk);
      cpu_rst_n = 1'b1;
    end
    do_access(1, 0, 32'h44, 32'h0, 1, 32'h4444_4444, 32'h4444_4444, 2, 0);

    // Misaligned load: no bus cycle, one stall cycle, mem_din cleared
    do_access(1, 0, 32'h3, 32'h0, 1, 32'h0, 32'h0, 1, 1);
    @(negedge clk);
    mem_ren = 1'b0;
    repeat (3) @(negedge clk);
    check("exp_q_empty", exp_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
